// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS32 DIV/DIVU.
// Quotient drives LO and remainder drives HI, with a one-cycle HI/LO write pulse.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             whilo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic             neg_q, neg_r;

  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    abs_dvd = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    abs_dvs = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
    shifted = {prem, dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FREE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (annul_i) begin
      state_nxt = FREE;
    end else begin
      case (state)
        FREE:    if (start_i) state_nxt = (divisor_i == '0) ? BYZERO : ON;
        BYZERO:  state_nxt = END;
        ON:      if (cnt == LAST) state_nxt = END;
        END:     if (!start_i) state_nxt = FREE;
        default: state_nxt = FREE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      prem    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      ready_o <= 1'b0;
      whilo_o <= 1'b0;
      quot_o  <= '0;
      rem_o   <= '0;
    end else begin
      whilo_o <= 1'b0;
      if (annul_i) begin
        ready_o <= 1'b0;
      end else begin
        case (state)
          FREE: begin
            if (start_i && divisor_i != '0) begin
              dvd   <= abs_dvd;
              dvs   <= abs_dvs;
              prem  <= '0;
              cnt   <= '0;
              neg_q <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
              neg_r <= signed_i & dividend_i[WIDTH-1];
            end
          end
          BYZERO: begin
            quot_o <= '0;
            rem_o  <= '0;
          end
          ON: begin
            if (cnt != LAST) begin
              if (!diff[WIDTH]) begin
                prem <= diff[WIDTH-1:0];
                dvd  <= {dvd[WIDTH-2:0], 1'b1};
              end else begin
                prem <= shifted[WIDTH-1:0];
                dvd  <= {dvd[WIDTH-2:0], 1'b0};
              end
              cnt <= cnt + CW'(1);
            end else begin
              quot_o  <= neg_q ? -dvd : dvd;
              rem_o   <= neg_r ? -prem : prem;
              ready_o <= 1'b1;
              whilo_o <= 1'b1;
            end
          end
          END: begin
            // The divide-by-zero path raises ready on its first END edge, so the write pulse fires there.
            if (!start_i) begin
              ready_o <= 1'b0;
            end else if (!ready_o) begin
              ready_o <= 1'b1;
              whilo_o <= 1'b1;
            end
          end
          default: ready_o <= 1'b0;
        endcase
      end
    end
  end

  assign hi_o = rem_o;
  assign lo_o = quot_o;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: results, latency, write pulse, annul and async reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        ready_o, whilo_o;
  logic [31:0] quot_o, rem_o, hi_o, lo_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i), .annul_i(annul_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .ready_o(ready_o), .quot_o(quot_o),
    .rem_o(rem_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Starts a divide, scrambles the operands after the sampling edge and checks
  // latency, result, write pulse, hold while start stays high and release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input int lat_exp);
    int lat;
    int whilo_seen;
    lat = 99;
    whilo_seen = 0;
    @(negedge clk);
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e == 0) begin
        dividend_i = ~a;
        divisor_i  = b + 32'd3;
      end
      if (whilo_o) whilo_seen++;
      if (ready_o) begin
        lat = e;
        break;
      end
    end
    check({tag, " latency"}, lat, lat_exp);
    check({tag, " whilo first"}, {31'd0, whilo_o}, 32'd1);
    check({tag, " lo"}, lo_o, eq);
    check({tag, " hi"}, hi_o, er);
    check({tag, " quot"}, quot_o, eq);
    check({tag, " rem"}, rem_o, er);
    @(posedge clk); #1;
    if (whilo_o) whilo_seen++;
    check({tag, " hold ready"}, {31'd0, ready_o}, 32'd1);
    check({tag, " hold lo"}, lo_o, eq);
    check({tag, " whilo count"}, whilo_seen, 32'd1);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, " release ready"}, {31'd0, ready_o}, 32'd0);
    check({tag, " release whilo"}, {31'd0, whilo_o}, 32'd0);
  endtask

  initial begin
    int whilo_seen;
    #12;
    check("reset ready", {31'd0, ready_o}, 32'd0);
    check("reset whilo", {31'd0, whilo_o}, 32'd0);
    check("reset quot", quot_o, 32'd0);
    check("reset rem", rem_o, 32'd0);
    check("reset hi", hi_o, 32'd0);
    check("reset lo", lo_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div("u100/7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33);
    run_div("s-7/2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33);
    run_div("s7/-2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33);
    run_div("div0",      1'b0, 32'h1234,       32'd0,          32'd0,          32'd0,          2);
    run_div("smin/-1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33);
    run_div("umax/1",    1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33);
    run_div("u5/9",      1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          33);

    // Annul while cnt=10: state returns to FREE, no write issued.
    @(negedge clk);
    signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd7; start_i = 1'b1;
    whilo_seen = 0;
    for (int e = 0; e <= 10; e++) begin
      @(posedge clk); #1;
      if (whilo_o) whilo_seen++;
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    check("annul ready", {31'd0, ready_o}, 32'd0);
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (whilo_o || ready_o) whilo_seen++;
    end
    check("annul no write", whilo_seen, 32'd0);
    check("annul lo kept", lo_o, 32'd0);
    run_div("u9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Async reset mid-divide clears the held 9/3 results without a clock edge.
    @(negedge clk);
    signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd7; start_i = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    check("pre-rst lo", lo_o, 32'd3);
    rst = 1'b0;
    #1;
    check("rst ready", {31'd0, ready_o}, 32'd0);
    check("rst whilo", {31'd0, whilo_o}, 32'd0);
    check("rst quot", quot_o, 32'd0);
    check("rst rem", rem_o, 32'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div("u20/6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for MIPS32 DIV and DIVU.
- Sits beside the EX stage and is the producer for the HI/LO register write port: quotient goes to LO, remainder goes to HI.
- EX holds start_i and stalls the pipeline until ready_o.
- Issues a single-cycle HI/LO write pulse when the result is final.

Parameters:
- WIDTH, 32, operand and quotient/remainder width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low: rst=0 clears all state immediately, independent of clk.
- start_i  input  1  level request from EX; held high until ready_o is seen.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- annul_i  input  1  flush/cancel of the current operation, from exception/branch logic.
- dividend_i  input  WIDTH  operand rs.
- divisor_i  input  WIDTH  operand rt.
- ready_o  output  1  result valid; EX releases its stall.
- quot_o  output  WIDTH  final quotient.
- rem_o  output  WIDTH  final remainder.
- whilo_o  output  1  one-cycle write enable toward the HI/LO write port.
- hi_o  output  WIDTH  HI write data, equal to rem_o.
- lo_o  output  WIDTH  LO write data, equal to quot_o.

Behaviour:
- Reset values: state=FREE, cnt=0; ready_o, whilo_o, quot_o, rem_o, hi_o, lo_o all 0.
- All outputs are registered.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, divisor_i=0 -> BYZERO.
  - start_i=1, annul_i=0, divisor_i!=0 -> ON.
  - On entry to ON: latch |dividend| and |divisor| (absolute value when signed_i=1, raw otherwise); latch the sign flags; clear the partial remainder; cnt=0.
  - Otherwise stay in FREE.
- BYZERO: unconditional -> END with quot=0 and rem=0. No exception is raised; the result is architecturally undefined but fixed here to 0.
- ON, cnt<WIDTH: one iteration per edge.
  - Shift {rem,quot} left by 1.
  - Trial subtract divisor from the upper WIDTH+1 bits. If non-negative, keep the difference and set quot LSB=1; else restore and set LSB=0.
  - cnt+1.
- ON, cnt==WIDTH: sign fix-up edge, then -> END.
  - Quotient is negated if signed_i and the operand signs differ.
  - Remainder takes the sign of the dividend.
  - The fix-up is written into quot_o/rem_o/hi_o/lo_o.
- END:
  - ready_o=1 while in END.
  - whilo_o=1 only on the first END cycle.
  - start_i=0 -> FREE; ready_o clears on the same edge.
  - start_i=1 -> stay in END with results stable and no further whilo_o.
- Latency, counting the edge that samples start in FREE as edge 0:
  - Normal divide: ready_o and whilo_o high after edge WIDTH+1 (edge 33).
  - Divide by zero: ready_o and whilo_o high after edge 2.
- annul_i=1 in any state -> FREE on the next edge.
  - ready_o and whilo_o forced to 0 on that edge.
  - The result is discarded and no HI/LO write is issued.
  - annul_i has priority over start_i.
- Overflow case (signed -2^31 / -1): quot=0x80000000, rem=0, no trap.
- Operands are sampled only at FREE->ON; changes on dividend_i/divisor_i during ON are ignored.
- Async reset asserted mid-operation:
  - All outputs go to 0 without waiting for a clock edge.
  - After rst deasserts, the unit is in FREE and accepts start on the next edge.

Test Plan:
- Unsigned 100/7 (signed_i=0): start at edge 0 -> ready_o=1 after edge 33; quot_o=14, rem_o=2, hi_o=2, lo_o=14; whilo_o high exactly 1 cycle; ready_o stays 1 while start_i=1 and drops 1 edge after start_i=0.
- Signed -7/2 (0xFFFFFFF9/0x00000002, signed_i=1) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. Also 7/-2 -> lo_o=0xFFFFFFFD, hi_o=0x00000001.
- Divide by zero 0x1234/0 -> ready_o and whilo_o high after edge 2 with quot_o=0 and rem_o=0.
- Edge values:
  - Signed 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
  - Unsigned 0xFFFFFFFF/1 -> lo_o=0xFFFFFFFF, hi_o=0.
  - Unsigned 5/9 -> lo_o=0, hi_o=5.
- annul_i pulsed when cnt=10 -> FREE next edge; whilo_o never asserts; a new start for 9/3 then completes normally with lo_o=3, hi_o=0 after 33 edges.
- rst driven low between clock edges during ON -> ready_o, whilo_o, quot_o, rem_o all 0 immediately; after rst returns high, a new 20/6 divide yields lo_o=3, hi_o=2.
